led_alert_ctrl: RTL and testbench
=================================

// Module: led_alert_ctrl
// PURPOSE
// - Parametrised countdown-urgency LED driver for the guess-number game; sits between the game timer/checker and the board LED bank.
// - Shows the LEDs solid while plenty of time remains, blinks slow then fast as the countdown nears zero, and latches a terminal display on win or timeout.
// - Successor to the fixed 8-LED/100 MHz blinker: adds generic clock rate, LED count, thresholds and a latched end state with a clear input.
// - Blink phase realigns on every mode change.
// PARAMETERS
// - CLK_HZ   100_000_000  clk frequency; base tick period = CLK_HZ/2 cycles (0.5 s)
// - N_LED    8            number of LED outputs
// - SEC_W    8            width of second input
// - N_CHK    6            width of check_result; win when all bits 1
// - SLOW_TH  10           second <= SLOW_TH (and > FAST_TH) -> slow blink
// - FAST_TH  3            second <= FAST_TH (and > 0) -> fast blink
// PORTS
// - clk           in   1       clock
// - rst           in   1       synchronous, active-high reset
// - second        in   SEC_W   remaining seconds from game timer
// - timer_finish  in   1       level, timer expired
// - check_result  in   N_CHK   per-digit match flags
// - clear         in   1       1-cycle pulse, leave terminal state (new round)
// - led           out  N_LED   LED drive, 1 = on
// - mode          out  3       current state encoding (debug/status)
// BEHAVIOUR
// - Reset: state STEADY, led = all 1, tick counter = 0, blink divider = 0.
// - Tick: counter 0..CLK_HZ/2-1, tick pulse when counter wraps; counter and divider reset on every state change.
// - States, evaluated each cycle in priority order:
//   - WON: entered when &check_result; led behaviour per CONFIGURATION.
//   - EXPIRED: entered when timer_finish; led = all 1.
//   - STEADY: second > SLOW_TH; led = all 1.
//   - SLOW: FAST_TH < second <= SLOW_TH; toggle all led every 2nd tick (1 s on / 1 s off).
//   - FAST: 0 < second <= FAST_TH; toggle all led every tick (0.5 s on / 0.5 s off).
//   - HOLD: second == 0 and no finish/win; led frozen at last value, counter stopped.
// - WON and EXPIRED latch: held until clear, ignoring second and timer_finish; clear -> re-evaluate next cycle from STEADY rules.
// - Win and timer_finish in same cycle: WON wins.
// - clear while not terminal: no effect.
// - Entering SLOW/FAST from any state: led forced all 1 same edge; first toggle after full half/whole period.
// - second rising (e.g. FAST->SLOW): legal, phase realigned as above.
// - Latency: input change -> state/led update on next clk edge (1 cycle).
// - Thresholds compared unsigned at SEC_W bits; require FAST_TH < SLOW_TH < 2**SEC_W.
// - rst mid-blink: immediate return to reset values.
// CONFIGURATION
// - Macro LED_ALERT_CHASE_EN.
//   - Defined: WON shows running light; entry led = 1 at bit 0, rotate left by one bit per tick, wrap bit N_LED-1 -> bit 0.
//   - Undefined: WON shows led = all 1, identical to EXPIRED.
// STRUCTURE
// - Package led_alert_pkg: state enum (STEADY, SLOW, FAST, HOLD, EXPIRED, WON) and mode encodings; TICK_CYC = CLK_HZ/2 helper function.
// - Sub-module led_tick_gen: parametrised wrap counter with sync clear and enable; outputs 1-cycle tick.
// - Top: state FSM plus LED register.
// TESTING
// - Setup: CLK_HZ = 8 (tick every 4 cycles), N_LED = 8.
// - Reset release, second = 20 -> led = 8'hFF, mode STEADY, stays constant 40 cycles.
// - Step second 20 -> 7 -> led 8'hFF for 8 cycles, then 8'h00 for 8, then 8'hFF (8-cycle half period).
// - second = 2 -> toggle every 4 cycles.
//   - Then second = 0 -> led frozen at current value.
//   - Then timer_finish = 1 -> 8'hFF, held while second changes, until clear.
// - check_result = 6'h3F with timer_finish = 1 same cycle -> mode WON.
//   - Chase on: led 01, 02, 04 ... 80, 01 every 4 cycles.
//   - Chase off: 8'hFF.
// - rst asserted mid-FAST blink -> next cycle led = 8'hFF, mode STEADY, counter 0.
// - clear pulse in WON with second = 5 -> mode SLOW next cycle, led 8'hFF, first toggle 8 cycles later.

Source files
------------

// File: rtl/led_alert_pkg.sv
// Shared types and helpers for the countdown-urgency LED driver.
// State enum values double as the externally visible mode encoding.
package led_alert_pkg;

  typedef enum logic [2:0] {
    STEADY  = 3'd0,
    SLOW    = 3'd1,
    FAST    = 3'd2,
    HOLD    = 3'd3,
    EXPIRED = 3'd4,
    WON     = 3'd5
  } state_t;

  localparam int MODE_W = 3;

  // Base tick period is half a second; never let it collapse below one cycle.
  function automatic int tick_cyc(input int clk_hz);
    return (clk_hz / 2 < 1) ? 1 : clk_hz / 2;
  endfunction

  function automatic logic is_terminal(input state_t s);
    return (s == WON) || (s == EXPIRED);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Wrap counter 0..TICK_CYC-1 with synchronous clear and enable;
// emits a one-cycle tick on the cycle the counter wraps.
module led_tick_gen #(
  parameter int TICK_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/led_alert.sv
// Countdown-urgency LED driver: solid, slow blink, fast blink, hold, latched end states.
// Define LED_ALERT_CHASE_EN to show a running light in WON instead of all-on.
module led_alert_ctrl
  import led_alert_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int N_LED   = 8,
  parameter int SEC_W   = 8,
  parameter int N_CHK   = 6,
  parameter int SLOW_TH = 10,
  parameter int FAST_TH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEC_W-1:0]  second,
  input  logic              timer_finish,
  input  logic [N_CHK-1:0]  check_result,
  input  logic              clear,
  output logic [N_LED-1:0]  led,
  output logic [MODE_W-1:0] mode
);

  localparam int TICK_CYC = tick_cyc(CLK_HZ);
  localparam logic [SEC_W-1:0] SLOW_V = SEC_W'(SLOW_TH);
  localparam logic [SEC_W-1:0] FAST_V = SEC_W'(FAST_TH);
  localparam logic [N_LED-1:0] ALL_ON = '1;
  localparam logic [N_LED-1:0] CHASE_INIT = N_LED'(1);

  state_t state;
  state_t nxt;
  logic   div;
  logic   tick;
  logic   chg;

  function automatic state_t countdown_state(input logic [SEC_W-1:0] s);
    if (s > SLOW_V)      return STEADY;
    else if (s > FAST_V) return SLOW;
    else if (s != '0)    return FAST;
    else                 return HOLD;
  endfunction

  // Terminal states ignore win/finish on the clearing cycle so a new round starts clean.
  // NOTE: every combinational output gets a default first, so no latch can be inferred.
  always_comb begin
    nxt = state;
    if (is_terminal(state)) begin
      if (clear) nxt = countdown_state(second);
    end else if (&check_result) begin
      nxt = WON;
    end else if (timer_finish) begin
      nxt = EXPIRED;
    end else begin
      nxt = countdown_state(second);
    end
  end

  assign chg = (nxt != state);

  led_tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (chg),
    .en   (state != HOLD),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STEADY;
      led   <= ALL_ON;
      div   <= 1'b0;
    end else begin
      state <= nxt;
      if (chg) begin
        // Every state change realigns the blink phase from an all-on start.
        div <= 1'b0;
        case (nxt)
          HOLD:    led <= led;
`ifdef LED_ALERT_CHASE_EN
          WON:     led <= CHASE_INIT;
`else
          WON:     led <= ALL_ON;
`endif
          default: led <= ALL_ON;
        endcase
      end else begin
        case (state)
          SLOW: begin
            if (tick) begin
              div <= ~div;
              if (div) led <= ~led;
            end
          end
          FAST: begin
            if (tick) led <= ~led;
          end
`ifdef LED_ALERT_CHASE_EN
          WON: begin
            if (tick) led <= {led[N_LED-2:0], led[N_LED-1]};
          end
`endif
          HOLD:    led <= led;
          default: led <= ALL_ON;
        endcase
      end
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_led_alert_ctrl.sv
// Scoreboard bench for led_alert_ctrl at CLK_HZ = 8 (tick every 4 cycles).
// Honours LED_ALERT_CHASE_EN for the WON display expectations.
module tb_led_alert_ctrl;
  import led_alert_pkg::*;

  typedef struct packed {
    logic [7:0] led;
    logic [2:0] mode;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] second;
  logic       timer_finish;
  logic [5:0] check_result;
  logic       clear;
  logic [7:0] led;
  logic [2:0] mode;

  exp_t q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  led_alert_ctrl #(
    .CLK_HZ  (8),
    .N_LED   (8),
    .SEC_W   (8),
    .N_CHK   (6),
    .SLOW_TH (10),
    .FAST_TH (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .second       (second),
    .timer_finish (timer_finish),
    .check_result (check_result),
    .clear        (clear),
    .led          (led),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  // Monitor: every cycle is an output sample; pop the expectation queued at the preceding edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      vectors++;
      if (led !== mon_e.led || mode !== mon_e.mode) begin
        miscompares++;
        $display("FAIL vec%0d led/mode: got led=%h mode=%0d, expected led=%h mode=%0d",
                 vectors, led, mode, mon_e.led, mon_e.mode);
      end
    end
  end

  task automatic cyc(input logic [7:0] el, input state_t em);
    exp_t e;
    @(posedge clk);
    e.led  = el;
    e.mode = em;
    q.push_back(e);
    #1;
  endtask

  task automatic rep(input int n, input logic [7:0] el, input state_t em);
    for (int i = 0; i < n; i++) cyc(el, em);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; second = 8'd20; timer_finish = 1'b0; check_result = 6'h00; clear = 1'b0;
    rep(2, 8'hFF, STEADY);
    rst = 1'b0;
    rep(40, 8'hFF, STEADY);

    // Slow blink: 8 cycles on, 8 off, then on again
    second = 8'd7;
    rep(8, 8'hFF, SLOW);
    rep(8, 8'h00, SLOW);
    rep(4, 8'hFF, SLOW);

    // Fast blink: 4-cycle half period
    second = 8'd2;
    rep(4, 8'hFF, FAST);
    rep(4, 8'h00, FAST);
    rep(4, 8'hFF, FAST);
    rep(2, 8'h00, FAST);

    // Zero seconds: frozen at current (off) value
    second = 8'd0;
    rep(10, 8'h00, HOLD);

    // Timeout latches all-on regardless of second/timer_finish
    timer_finish = 1'b1;
    rep(3, 8'hFF, EXPIRED);
    second = 8'd30;
    rep(3, 8'hFF, EXPIRED);
    second = 8'd2;
    rep(3, 8'hFF, EXPIRED);
    timer_finish = 1'b0;
    rep(3, 8'hFF, EXPIRED);

    // Clear out of EXPIRED into FAST with realigned phase
    clear = 1'b1;
    cyc(8'hFF, FAST);
    clear = 1'b0;
    rep(3, 8'hFF, FAST);
    rep(2, 8'h00, FAST);

    // Reset mid-blink, then fresh FAST entry from counter 0
    rst = 1'b1;
    cyc(8'hFF, STEADY);
    rst = 1'b0;
    rep(4, 8'hFF, FAST);
    cyc(8'h00, FAST);

    // Win and timeout together: WON has priority
    check_result = 6'h3F; timer_finish = 1'b1;
    for (int k = 0; k < 9; k++) begin
`ifdef LED_ALERT_CHASE_EN
      w = 8'h01 << (k % 8);
`else
      w = 8'hFF;
`endif
      if (k == 4) second = 8'd0;
      rep(4, w, WON);
    end

    // Clear out of WON into SLOW
    check_result = 6'h00; timer_finish = 1'b0; second = 8'd5; clear = 1'b1;
    cyc(8'hFF, SLOW);
    clear = 1'b0;
    rep(7, 8'hFF, SLOW);
    cyc(8'h00, SLOW);

    // Clear outside a terminal state changes nothing
    clear = 1'b1;
    cyc(8'h00, SLOW);
    clear = 1'b0;
    cyc(8'h00, SLOW);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
